// File: rtl/cache_param_pkg.sv
// Shared far-memory request types and sizing constants for the cache controller.
package cache_param_pkg;

  localparam int NUM_TQ_ENTRY = 8;
  localparam int FM_WR_DEPTH  = 4;
  localparam int TQ_ID_W      = $clog2(NUM_TQ_ENTRY);
  localparam int FM_ADDR_W    = 32;
  localparam int FM_DATA_W    = 64;
  // 64-byte cache lines: a line is identified by address[MSB_TAG:LSB_SET].
  localparam int MSB_TAG      = FM_ADDR_W - 1;
  localparam int LSB_SET      = 6;
  localparam int FM_LINE_W    = MSB_TAG - LSB_SET + 1;

  typedef enum logic [1:0] {
    NOP_OP = 2'd0,
    RD_OP  = 2'd1,
    WR_OP  = 2'd2
  } t_fm_opcode;

  typedef struct packed {
    logic                 valid;
    logic [TQ_ID_W-1:0]   tq_id;
    logic [FM_ADDR_W-1:0] address;
  } t_fm_rd_req;

  typedef struct packed {
    logic                 valid;
    logic [FM_ADDR_W-1:0] address;
    logic [FM_DATA_W-1:0] data;
  } t_fm_wr_req;

  typedef struct packed {
    logic                 valid;
    t_fm_opcode           opcode;
    logic [TQ_ID_W-1:0]   tq_id;
    logic [FM_ADDR_W-1:0] address;
    logic [FM_DATA_W-1:0] data;
  } t_fm_req;

  typedef struct packed {
    logic [TQ_ID_W-1:0]   tq_id;
    logic [FM_ADDR_W-1:0] address;
  } t_fm_rd_ent;

  typedef struct packed {
    logic [FM_ADDR_W-1:0] address;
    logic [FM_DATA_W-1:0] data;
  } t_fm_wr_ent;

endpackage

// File: rtl/cache_fm_fifo.sv
// Generic power-of-two circular FIFO; also exposes a key slice and a valid bit
// for every slot so the owner can snoop buffered entries.
module cache_fm_fifo #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int KEY_LSB = 0,
  parameter int KEY_W   = 1,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            din_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            dout_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [CNT_W-1:0]            count_o,
  output logic [DEPTH-1:0][KEY_W-1:0] keys_o,
  output logic [DEPTH-1:0]            slot_vld_o
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        push_ok;
  logic                        pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_comb begin
    logic [PTR_W-1:0] offs;
    offs = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs          = PTR_W'(i) - rd_ptr_q;
      keys_o[i]     = mem_q[i][KEY_LSB +: KEY_W];
      slot_vld_o[i] = (CNT_W'(offs) < count_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/cache_fm_req_arb.sv
// Far-memory request arbiter: read-miss and write-back buffers feeding one
// registered request port. CACHE_FM_RAW_CHECK_EN selects RAW-checked read priority.
module cache_fm_req_arb
  import cache_param_pkg::*;
#(
  parameter int WR_DEPTH     = FM_WR_DEPTH,
  parameter int RD_DEPTH     = NUM_TQ_ENTRY,
  parameter int STARVE_LIMIT = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  t_fm_rd_req fm_rd_req_in,
  input  t_fm_wr_req fm_wr_req_in,
  output logic       rd_buf_full,
  output logic       wr_buf_full,
  output t_fm_req    fm_req_out,
  input  logic       fm_req_ready,
  output logic       overflow_err
);

  localparam int RD_CNT_W = $clog2(RD_DEPTH + 1);
  localparam int WR_CNT_W = $clog2(WR_DEPTH + 1);
  localparam int STV_W    = $clog2(STARVE_LIMIT + 1);

  t_fm_req    fm_req_q, fm_req_d;
  logic       overflow_q, overflow_d;
  logic [STV_W-1:0] starve_q, starve_d;

  t_fm_rd_ent rd_din, rd_dout, rd_head;
  t_fm_wr_ent wr_din, wr_dout, wr_head;
  logic       rd_full, rd_empty, wr_full, wr_empty;
  logic       rd_push_v, wr_push_v;
  logic       rd_avail, wr_avail;
  logic       rd_grant, wr_grant;
  logic       rd_fifo_push, rd_fifo_pop, wr_fifo_push, wr_fifo_pop;
  logic       out_load;

  logic [RD_CNT_W-1:0]                rd_unused_count;
  logic [WR_CNT_W-1:0]                wr_unused_count;
  logic [RD_DEPTH-1:0][FM_LINE_W-1:0] rd_unused_keys;
  logic [RD_DEPTH-1:0]                rd_unused_vld;
  logic [WR_DEPTH-1:0][FM_LINE_W-1:0] wr_keys;
  logic [WR_DEPTH-1:0]                wr_slot_vld;

  assign rd_push_v = fm_rd_req_in.valid;
  assign wr_push_v = fm_wr_req_in.valid;
  assign rd_din    = '{tq_id: fm_rd_req_in.tq_id, address: fm_rd_req_in.address};
  assign wr_din    = '{address: fm_wr_req_in.address, data: fm_wr_req_in.data};

  // An empty buffer forwards its incoming push straight to arbitration so a
  // request reaches the output register one cycle after it is presented.
  assign rd_avail = !rd_empty || rd_push_v;
  assign wr_avail = !wr_empty || wr_push_v;
  assign rd_head  = rd_empty ? rd_din : rd_dout;
  assign wr_head  = wr_empty ? wr_din : wr_dout;

  assign out_load = !fm_req_q.valid || fm_req_ready;

  assign rd_fifo_pop  = rd_grant && !rd_empty;
  assign wr_fifo_pop  = wr_grant && !wr_empty;
  assign rd_fifo_push = rd_push_v && !(rd_grant && rd_empty);
  assign wr_fifo_push = wr_push_v && !(wr_grant && wr_empty);

  cache_fm_fifo #(
    .WIDTH   ($bits(t_fm_rd_ent)),
    .DEPTH   (RD_DEPTH),
    .KEY_LSB (LSB_SET),
    .KEY_W   (FM_LINE_W)
  ) u_rd_fifo (
    .clk_i      (Clk),
    .rst_i      (Rst),
    .push_i     (rd_fifo_push),
    .din_i      (rd_din),
    .pop_i      (rd_fifo_pop),
    .dout_o     (rd_dout),
    .full_o     (rd_full),
    .empty_o    (rd_empty),
    .count_o    (rd_unused_count),
    .keys_o     (rd_unused_keys),
    .slot_vld_o (rd_unused_vld)
  );

  cache_fm_fifo #(
    .WIDTH   ($bits(t_fm_wr_ent)),
    .DEPTH   (WR_DEPTH),
    .KEY_LSB (FM_DATA_W + LSB_SET),
    .KEY_W   (FM_LINE_W)
  ) u_wr_fifo (
    .clk_i      (Clk),
    .rst_i      (Rst),
    .push_i     (wr_fifo_push),
    .din_i      (wr_din),
    .pop_i      (wr_fifo_pop),
    .dout_o     (wr_dout),
    .full_o     (wr_full),
    .empty_o    (wr_empty),
    .count_o    (wr_unused_count),
    .keys_o     (wr_keys),
    .slot_vld_o (wr_slot_vld)
  );

`ifdef CACHE_FM_RAW_CHECK_EN
  logic raw_hit;

  // Any older write to the read head's line (buffered, arriving, or sitting
  // un-handshaken in the output register) must reach far memory first.
  always_comb begin
    raw_hit = 1'b0;
    for (int i = 0; i < WR_DEPTH; i++) begin
      if (wr_slot_vld[i] && (wr_keys[i] == rd_head.address[MSB_TAG:LSB_SET])) begin
        raw_hit = 1'b1;
      end
    end
    if (wr_push_v && (fm_wr_req_in.address[MSB_TAG:LSB_SET] == rd_head.address[MSB_TAG:LSB_SET])) begin
      raw_hit = 1'b1;
    end
    if (fm_req_q.valid && (fm_req_q.opcode == WR_OP) &&
        (fm_req_q.address[MSB_TAG:LSB_SET] == rd_head.address[MSB_TAG:LSB_SET])) begin
      raw_hit = 1'b1;
    end
  end

  always_comb begin
    rd_grant = 1'b0;
    wr_grant = 1'b0;
    if (out_load) begin
      if (wr_avail && (!rd_avail || (starve_q == STV_W'(STARVE_LIMIT)) || raw_hit)) begin
        wr_grant = 1'b1;
      end else if (rd_avail && !raw_hit) begin
        rd_grant = 1'b1;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (wr_grant || !wr_avail) begin
      starve_d = '0;
    end else if (rd_grant) begin
      starve_d = starve_q + STV_W'(1);
    end
  end
`else
  logic unused_wr_snoop;

  always_comb begin
    rd_grant = 1'b0;
    wr_grant = 1'b0;
    if (out_load) begin
      if (wr_avail) begin
        wr_grant = 1'b1;
      end else if (rd_avail) begin
        rd_grant = 1'b1;
      end
    end
  end

  assign starve_d        = '0;
  assign unused_wr_snoop = ^{wr_keys, wr_slot_vld, starve_q};
`endif

  always_comb begin
    fm_req_d = fm_req_q;
    if (out_load) begin
      fm_req_d = '0;
      if (rd_grant) begin
        fm_req_d.valid   = 1'b1;
        fm_req_d.opcode  = RD_OP;
        fm_req_d.tq_id   = rd_head.tq_id;
        fm_req_d.address = rd_head.address;
      end else if (wr_grant) begin
        fm_req_d.valid   = 1'b1;
        fm_req_d.opcode  = WR_OP;
        fm_req_d.address = wr_head.address;
        fm_req_d.data    = wr_head.data;
      end
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if ((rd_push_v && rd_full && !rd_fifo_pop) || (wr_push_v && wr_full && !wr_fifo_pop)) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      fm_req_q   <= '0;
      overflow_q <= 1'b0;
      starve_q   <= '0;
    end else begin
      fm_req_q   <= fm_req_d;
      overflow_q <= overflow_d;
      starve_q   <= starve_d;
    end
  end

  assign fm_req_out   = fm_req_q;
  assign overflow_err = overflow_q;
  assign rd_buf_full  = rd_full;
  assign wr_buf_full  = wr_full;

endmodule

// File: tb/tb_cache_fm_req_arb.sv
// Directed self-checking bench for cache_fm_req_arb (either macro setting).
module tb_cache_fm_req_arb;
  import cache_param_pkg::*;

  logic       Clk = 1'b0;
  logic       Rst;
  t_fm_rd_req rd_in;
  t_fm_wr_req wr_in;
  logic       ready;
  t_fm_req    req_out;
  logic       rd_full, wr_full, ovf;
  int         checks = 0;
  int         errors = 0;
  logic       seen;

  always #5 Clk = ~Clk;

  cache_fm_req_arb dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .fm_rd_req_in (rd_in),
    .fm_wr_req_in (wr_in),
    .rd_buf_full  (rd_full),
    .wr_buf_full  (wr_full),
    .fm_req_out   (req_out),
    .fm_req_ready (ready),
    .overflow_err (ovf)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic t_fm_req mk(input t_fm_opcode op, input logic [TQ_ID_W-1:0] tq,
                                 input logic [FM_ADDR_W-1:0] a, input logic [FM_DATA_W-1:0] d);
    t_fm_req r;
    r.valid   = 1'b1;
    r.opcode  = op;
    r.tq_id   = tq;
    r.address = a;
    r.data    = d;
    return r;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    rd_in = '0;
    wr_in = '0;
  endtask

  task automatic push_rd(input logic [TQ_ID_W-1:0] tq, input logic [FM_ADDR_W-1:0] a);
    rd_in.valid   = 1'b1;
    rd_in.tq_id   = tq;
    rd_in.address = a;
  endtask

  task automatic push_wr(input logic [FM_ADDR_W-1:0] a, input logic [FM_DATA_W-1:0] d);
    wr_in.valid   = 1'b1;
    wr_in.address = a;
    wr_in.data    = d;
  endtask

  // Waits (bounded) for the next valid request with ready held high and checks it.
  task automatic expect_xfer(input string tag, input t_fm_req e);
    int n;
    n = 0;
    while (!req_out.valid && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 128'(req_out), 128'(e));
    tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst   = 1'b1;
    ready = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_out", 128'(req_out), 128'(0));
    chk("rst_rdfull", 128'(rd_full), 128'(0));
    chk("rst_wrfull", 128'(wr_full), 128'(0));
    chk("rst_ovf", 128'(ovf), 128'(0));
    Rst = 1'b0;

    // single read, one-cycle latency
    ready = 1'b1;
    push_rd(3'd3, 32'h12340);
    tick();
    idle();
    chk("rd1_out", 128'(req_out), 128'(mk(RD_OP, 3'd3, 32'h12340, 64'h0)));
    tick();
    chk("rd1_gone", 128'(req_out.valid), 128'(0));

    // backpressure holds fields, then exactly one transfer
    ready = 1'b0;
    push_rd(3'd5, 32'h2000);
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", 128'(req_out), 128'(mk(RD_OP, 3'd5, 32'h2000, 64'h0)));
      tick();
    end
    ready = 1'b1;
    tick();
    chk("bp_one", 128'(req_out.valid), 128'(0));
    tick();
    chk("bp_one2", 128'(req_out.valid), 128'(0));

    // RAW: write to line 0xA40 must leave before the read of 0xA58
    ready = 1'b0;
    push_rd(3'd1, 32'h4000);
    tick();
    idle();
    push_wr(32'h00A50, 64'hDEAD);
    tick();
    idle();
    push_rd(3'd2, 32'h00A58);
    tick();
    idle();
    ready = 1'b1;
    expect_xfer("raw_dummy", mk(RD_OP, 3'd1, 32'h4000, 64'h0));
    expect_xfer("raw_wr", mk(WR_OP, 3'd0, 32'h00A50, 64'hDEAD));
    expect_xfer("raw_rd", mk(RD_OP, 3'd2, 32'h00A58, 64'h0));
    chk("raw_empty", 128'(req_out.valid), 128'(0));

    // starvation: 1 write + 8 reads on distinct lines
    ready = 1'b0;
    push_wr(32'h80000, 64'h55);
    push_rd(3'd0, 32'h1000);
    tick();
    idle();
    for (int i = 1; i < 8; i++) begin
      push_rd(TQ_ID_W'(i), 32'h1000 + 32'(i) * 32'h40);
      tick();
    end
    idle();
    ready = 1'b1;
`ifdef CACHE_FM_RAW_CHECK_EN
    for (int i = 0; i < 4; i++)
      expect_xfer("stv_rd_a", mk(RD_OP, TQ_ID_W'(i), 32'h1000 + 32'(i) * 32'h40, 64'h0));
    expect_xfer("stv_wr", mk(WR_OP, 3'd0, 32'h80000, 64'h55));
    for (int i = 4; i < 8; i++)
      expect_xfer("stv_rd_b", mk(RD_OP, TQ_ID_W'(i), 32'h1000 + 32'(i) * 32'h40, 64'h0));
`else
    expect_xfer("stv_wr", mk(WR_OP, 3'd0, 32'h80000, 64'h55));
    for (int i = 0; i < 8; i++)
      expect_xfer("stv_rd", mk(RD_OP, TQ_ID_W'(i), 32'h1000 + 32'(i) * 32'h40, 64'h0));
`endif
    chk("stv_empty", 128'(req_out.valid), 128'(0));

    // write buffer full, push+pop at full, then overflow drop
    ready = 1'b0;
    push_rd(3'd6, 32'h5000);
    tick();
    idle();
    for (int i = 1; i <= 4; i++) begin
      push_wr(32'h9000 + 32'(i) * 32'h40, 64'(i));
      tick();
      if (i == 3) chk("wr_full_3", 128'(wr_full), 128'(0));
      if (i == 4) chk("wr_full_4", 128'(wr_full), 128'(1));
    end
    ready = 1'b1;
    push_wr(32'h9000 + 32'd5 * 32'h40, 64'd5);
    tick();
    chk("pp_full", 128'(wr_full), 128'(1));
    chk("pp_noerr", 128'(ovf), 128'(0));
    ready = 1'b0;
    push_wr(32'h9000 + 32'd6 * 32'h40, 64'd6);
    tick();
    idle();
    chk("ovf_set", 128'(ovf), 128'(1));
    chk("ovf_full", 128'(wr_full), 128'(1));
    ready = 1'b1;
    for (int i = 1; i <= 5; i++)
      expect_xfer("ovf_drain", mk(WR_OP, 3'd0, 32'h9000 + 32'(i) * 32'h40, 64'(i)));
    chk("ovf_dropped", 128'(req_out.valid), 128'(0));

    // fill read buffer, then reset mid-operation
    ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      push_rd(TQ_ID_W'(i % 8), 32'h6000 + 32'(i) * 32'h40);
      if (i == 8) push_wr(32'hC000, 64'h77);
      tick();
      idle();
      if (i == 7) chk("rd_full_7", 128'(rd_full), 128'(0));
      if (i == 8) chk("rd_full_8", 128'(rd_full), 128'(1));
    end
    Rst = 1'b1;
    push_rd(3'd7, 32'h7000);
    push_wr(32'hD000, 64'h99);
    tick();
    idle();
    chk("mid_rst_out", 128'(req_out), 128'(0));
    chk("mid_rst_rdfull", 128'(rd_full), 128'(0));
    chk("mid_rst_wrfull", 128'(wr_full), 128'(0));
    chk("mid_rst_ovf", 128'(ovf), 128'(0));
    Rst   = 1'b0;
    ready = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (req_out.valid) seen = 1'b1;
      tick();
    end
    chk("no_stale", 128'(seen), 128'(0));
    push_rd(3'd2, 32'h8000);
    tick();
    idle();
    chk("post_rst_rd", 128'(req_out), 128'(mk(RD_OP, 3'd2, 32'h8000, 64'h0)));
    tick();
    chk("post_rst_gone", 128'(req_out.valid), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_fm_req_arb.md
CACHE_FM_REQ_ARB -- requirements
Module: cache_fm_req_arb

Interface
REQ-001 SHALL have parameter WR_DEPTH, default 4, meaning write-back buffer entries (power of 2).
REQ-002 SHALL have parameter RD_DEPTH, default NUM_TQ_ENTRY (8), meaning read-miss buffer entries (power of 2).
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum consecutive read grants while a write is pending.
REQ-004 SHALL have port Clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port Rst, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port fm_rd_req_in, input, t_fm_rd_req, meaning a miss read from the TQ, pushed when .valid=1.
REQ-007 SHALL have port fm_wr_req_in, input, t_fm_wr_req, meaning a dirty-evict write-back from the lookup pipe, pushed when .valid=1.
REQ-008 SHALL have port rd_buf_full, output, 1, meaning the read buffer count equals RD_DEPTH.
REQ-009 SHALL have port wr_buf_full, output, 1, meaning the write buffer count equals WR_DEPTH (the TQ rejects new misses while this is set).
REQ-010 SHALL have port fm_req_out, output, t_fm_req, meaning the registered far-memory request {valid, opcode, tq_id, address, data}.
REQ-011 SHALL have port fm_req_ready, input, 1, meaning far memory accepts fm_req_out this cycle.
REQ-012 SHALL have port overflow_err, output, 1, meaning a sticky flag set by a push into a full buffer.

Function
REQ-013 SHALL count a transfer only when fm_req_out.valid & fm_req_ready are both 1 in the same cycle; while valid & !ready, every fm_req_out field SHALL hold stable.
REQ-014 SHALL load the output register from the arbitration winner when the output register is empty or transferring this cycle (no bubble); the winner SHALL pop in that same cycle.
REQ-015 SHALL give a minimum latency of 1 cycle: a request pushed in cycle N into empty buffers with an empty output register SHALL appear on fm_req_out in cycle N+1.
REQ-016 SHALL allow a simultaneous push and pop on a buffer; the count is unchanged and both actions are applied, including when the buffer is full at cycle start.
REQ-017 SHALL ignore a push into a buffer that is full at cycle start with no pop in the same cycle; the buffer contents are not modified and overflow_err is set until Rst.
REQ-018 SHALL keep FIFO order within each buffer; read/write pointers wrap modulo depth.
REQ-019 SHALL arbitrate with default priority to reads (opcode RD_OP, tq_id from the request, data=0).
REQ-020 SHALL grant the write-buffer head (opcode WR_OP, tq_id=0) when the read buffer is empty, when the starve counter equals STARVE_LIMIT, or when the REQ-022 hazard holds.
REQ-021 SHALL increment the starve counter on a read grant while the write buffer is non-empty, and clear it on any write grant or when the write buffer is empty.
REQ-022 SHALL treat as a RAW hazard the case where read-head address[MSB_TAG:LSB_SET] matches any valid write-buffer entry or a pending WR_OP in the output register; a hazarded read SHALL NOT be granted until no match remains.
REQ-023 SHALL present equal-cycle pushes of a read and a write as independent; both are accepted if there is room.

Reset
REQ-024 SHALL, on Rst=1 at a rising edge, clear pointers, counts, starve counter, overflow_err and fm_req_out (all fields 0); rd_buf_full=0 and wr_buf_full=0.
REQ-025 SHALL discard buffered and in-flight (not yet handshaken) requests when Rst is asserted mid-operation, and drop pushes presented during that cycle.

Configuration
REQ-026 SHALL, when CACHE_FM_RAW_CHECK_EN is defined, implement REQ-022 address comparison.
REQ-027 SHALL, when CACHE_FM_RAW_CHECK_EN is undefined, omit the comparators and grant any non-empty write buffer before reads (strict write priority; REQ-021 starve counter unused, held 0).

Structure
REQ-028 SHALL add t_fm_req and the localparam FM_WR_DEPTH=4 to cache_param_pkg.
REQ-029 SHALL instantiate one generic sub-module cache_fm_fifo (parameterised width/depth, push/pop/full/empty/count), used twice; arbitration and the output register SHALL live in the top module.

Verification
REQ-030 SHALL verify single read: push rd tq_id=3 address=0x12340 in cycle 0 with ready=1 -> cycle 1 fm_req_out {valid=1, RD_OP, tq_id=3, 0x12340}, cycle 2 valid=0.
REQ-031 SHALL verify backpressure: ready=0 for 5 cycles with a read pending -> fields constant for 5 cycles; ready=1 -> exactly one transfer.
REQ-032 SHALL verify RAW (macro on): push wr 0x00A50 then rd 0x00A58 (same CL) -> WR_OP granted before RD_OP; with macro off -> same order due to strict write priority.
REQ-033 SHALL verify starvation: 1 write plus 8 non-conflicting reads, ready=1 (macro on) -> 4 reads, then write, then 4 reads.
REQ-034 SHALL verify full/overflow: 5 writes, ready=0 -> wr_buf_full=1 after the 4th, 5th dropped, overflow_err=1; push+pop when full -> count stays 4, no error.
REQ-035 SHALL verify reset mid-operation: Rst with 3 buffered entries and valid output -> next cycle all outputs 0, no stale requests after Rst deasserts.
